// File: rtl/bus_dma_if.sv
// Port bundle for bus_dma: transfer request inputs and two-phase bus signals.
// The fill-mode ports exist only when BUS_DMA_FILL_EN is defined.
interface bus_dma_if #(
  parameter int unsigned LEN_WIDTH = 16
);
  logic                 i_start;
  logic [15:0]          i_src_addr;
  logic [15:0]          i_dst_addr;
  logic [LEN_WIDTH-1:0] i_len;
  logic                 i_rdy;
  logic [7:0]           i_bus_data;
  logic [15:0]          o_bus_addr;
  logic [7:0]           o_bus_data;
  logic                 o_bus_rw;
  logic                 o_phi1;
  logic                 o_phi2;
  logic                 o_busy;
  logic                 o_done;
`ifdef BUS_DMA_FILL_EN
  logic                 i_fill;
  logic [7:0]           i_fill_data;

  modport master (
    input  i_start, i_src_addr, i_dst_addr, i_len, i_rdy, i_bus_data,
    input  i_fill, i_fill_data,
    output o_bus_addr, o_bus_data, o_bus_rw, o_phi1, o_phi2, o_busy, o_done
  );
  modport slave (
    output i_start, i_src_addr, i_dst_addr, i_len, i_rdy, i_bus_data,
    output i_fill, i_fill_data,
    input  o_bus_addr, o_bus_data, o_bus_rw, o_phi1, o_phi2, o_busy, o_done
  );
`else
  modport master (
    input  i_start, i_src_addr, i_dst_addr, i_len, i_rdy, i_bus_data,
    output o_bus_addr, o_bus_data, o_bus_rw, o_phi1, o_phi2, o_busy, o_done
  );
  modport slave (
    output i_start, i_src_addr, i_dst_addr, i_len, i_rdy, i_bus_data,
    input  o_bus_addr, o_bus_data, o_bus_rw, o_phi1, o_phi2, o_busy, o_done
  );
`endif
endinterface

// File: rtl/bus_dma.sv
// Byte-copy DMA initiator for a two-phase (phi1/phi2) bus.
// Optional BUS_DMA_FILL_EN adds a write-only fill mode with a latched pattern.
module bus_dma #(
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic      i_clk,
  input  logic      i_reset,
  bus_dma_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, RD_PHI1, RD_PHI2, WR_PHI1, WR_PHI2, FINISH
  } state_t;

  state_t               state, state_nx;
  logic [15:0]          src, dst;
  logic [LEN_WIDTH-1:0] len;
  logic [7:0]           data;
  logic                 zero_pend;
  logic                 fill_mode;

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    bus.o_bus_addr = '0;
    bus.o_bus_data = '0;
    bus.o_bus_rw   = 1'b1;
    bus.o_phi1     = 1'b0;
    bus.o_phi2     = 1'b0;
    bus.o_busy     = 1'b0;
    bus.o_done     = 1'b0;
    case (state)
      IDLE: begin
        // a zero-length request spends one extra clock here so its done pulse lands two clocks after start
        if (zero_pend)
          state_nx = FINISH;
        else if (bus.i_start && bus.i_len != '0)
          state_nx = fill_start() ? WR_PHI1 : RD_PHI1;
      end
      RD_PHI1: begin
        bus.o_busy     = 1'b1;
        bus.o_phi1     = 1'b1;
        bus.o_bus_addr = src;
        state_nx       = RD_PHI2;
      end
      RD_PHI2: begin
        bus.o_busy     = 1'b1;
        bus.o_phi2     = 1'b1;
        bus.o_bus_addr = src;
        if (bus.i_rdy) state_nx = WR_PHI1;
      end
      WR_PHI1: begin
        bus.o_busy     = 1'b1;
        bus.o_phi1     = 1'b1;
        bus.o_bus_rw   = 1'b0;
        bus.o_bus_addr = dst;
        bus.o_bus_data = data;
        state_nx       = WR_PHI2;
      end
      WR_PHI2: begin
        bus.o_busy     = 1'b1;
        bus.o_phi2     = 1'b1;
        bus.o_bus_rw   = 1'b0;
        bus.o_bus_addr = dst;
        bus.o_bus_data = data;
        if (len == LEN_WIDTH'(1)) state_nx = FINISH;
        else                      state_nx = fill_mode ? WR_PHI1 : RD_PHI1;
      end
      FINISH: begin
        bus.o_done = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      src       <= '0;
      dst       <= '0;
      len       <= '0;
      data      <= '0;
      zero_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (zero_pend) begin
            zero_pend <= 1'b0;
          end else if (bus.i_start) begin
            if (bus.i_len == '0) begin
              zero_pend <= 1'b1;
            end else begin
              src <= bus.i_src_addr;
              dst <= bus.i_dst_addr;
              len <= bus.i_len;
`ifdef BUS_DMA_FILL_EN
              if (bus.i_fill) data <= bus.i_fill_data;
`endif
            end
          end
        end
        RD_PHI2: if (bus.i_rdy) data <= bus.i_bus_data;
        WR_PHI2: begin
          src <= src + 16'd1;
          dst <= dst + 16'd1;
          len <= len - LEN_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef BUS_DMA_FILL_EN
  always_ff @(posedge i_clk) begin
    if (i_reset)
      fill_mode <= 1'b0;
    else if (state == IDLE && !zero_pend && bus.i_start && bus.i_len != '0)
      fill_mode <= bus.i_fill;
  end

  function automatic logic fill_start();
    return bus.i_fill;
  endfunction
`else
  assign fill_mode = 1'b0;

  function automatic logic fill_start();
    return 1'b0;
  endfunction
`endif
endmodule

// File: doc/bus_dma.md
BUS_DMA -- requirements
Module: bus_dma

Interface
REQ-001 SHALL provide parameter LEN_WIDTH, default 16, width of the transfer length counter (1..16).
REQ-002 SHALL provide i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL provide i_reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide i_start  input  1  one-clock request to begin a transfer.
REQ-005 SHALL provide i_src_addr, i_dst_addr  input  16 each  first source and destination byte addresses.
REQ-006 SHALL provide i_len  input  LEN_WIDTH  byte count.
REQ-007 SHALL provide i_rdy  input  1  bus ready; low stretches read cycles.
REQ-008 SHALL provide i_bus_data  input  8  read data from the bus target.
REQ-009 SHALL provide o_bus_addr  output  16; o_bus_data  output  8; o_bus_rw  output  1 (1 = read); o_phi1, o_phi2  output  1 each.
REQ-010 SHALL provide o_busy  output  1  transfer in progress; o_done  output  1  one-clock completion pulse.

Function
REQ-011 SHALL be a bus initiator on the two-phase bus; the bus target latches writes and presents reads during phi2.
REQ-012 SHALL implement states IDLE, RD_PHI1, RD_PHI2, WR_PHI1, WR_PHI2, FINISH.
REQ-013 SHALL, in IDLE with i_start high and i_len != 0, latch src, dst and len, assert o_busy next clock, and enter RD_PHI1.
REQ-014 SHALL, with i_start high and i_len == 0, skip all bus cycles and pulse o_done for one clock, with o_busy staying low, two clocks after i_start.
REQ-015 SHALL ignore i_start while o_busy is high.
REQ-016 SHALL drive o_phi1=1, o_phi2=0 in *_PHI1 states and o_phi1=0, o_phi2=1 in *_PHI2 states; both are 0 in IDLE and FINISH.
REQ-017 SHALL hold o_bus_addr = current src and o_bus_rw = 1 throughout RD_PHI1/RD_PHI2.
REQ-018 SHALL capture i_bus_data into an internal byte register on the last RD_PHI2 clock (i_rdy high), then enter WR_PHI1.
REQ-019 SHALL, in RD_PHI2 with i_rdy low, remain in RD_PHI2 without capturing data; i_rdy has no effect on write cycles.
REQ-020 SHALL hold o_bus_addr = current dst, o_bus_rw = 0 and o_bus_data = captured byte throughout WR_PHI1/WR_PHI2.
REQ-021 SHALL, on leaving WR_PHI2, increment src and dst modulo 2^16 (0xFFFF wraps to 0x0000) and decrement len.
REQ-022 SHALL go to FINISH if the decremented len is 0, else to RD_PHI1.
REQ-023 SHALL take 4 clocks per byte with i_rdy held high.
REQ-024 SHALL, in FINISH, pulse o_done for one clock, deassert o_busy and return to IDLE.
REQ-025 SHALL drive o_bus_rw=1, o_bus_addr=0x0000 and o_bus_data=0x00 whenever in IDLE or FINISH.

Reset
REQ-026 SHALL, with i_reset high, on the next clock enter IDLE, clear all counters and the data register, and drive o_busy=0, o_done=0, o_phi1=0, o_phi2=0, o_bus_rw=1, o_bus_addr=0x0000, o_bus_data=0x00.
REQ-027 SHALL, on reset mid-transfer, abandon the transfer with no o_done pulse; reset takes priority over i_start.

Configuration
REQ-028 SHALL, with BUS_DMA_FILL_EN defined, add ports i_fill (input 1) and i_fill_data (input 8), both latched at start.
REQ-029 SHALL, with BUS_DMA_FILL_EN defined and i_fill latched high, skip RD_PHI1/RD_PHI2, write the latched i_fill_data to each dst, and take 2 clocks per byte.
REQ-030 SHALL, without BUS_DMA_FILL_EN, omit both fill ports and support copy only.

Verification
REQ-031 SHALL cover the copy case: memory 0x0200..0x0203 = 11 22 33 44, src=0x0200, dst=0x0300, len=4 -> 0x0300..0x0303 = 11 22 33 44, o_done 16 clocks after busy rises.
REQ-032 SHALL cover the wrap case: src=0xFFFF, dst=0x7FFF, len=2 -> reads 0xFFFF then 0x0000; writes 0x7FFF then 0x8000.
REQ-033 SHALL cover the stretch case: i_rdy low for 3 clocks during the first RD_PHI2, len=1 -> o_bus_addr holds src, correct byte written, total 7 clocks.
REQ-034 SHALL cover zero length and start while busy: len=0 -> o_done pulse with no phi activity; i_start pulsed mid-transfer -> no effect on addresses or count.
REQ-035 SHALL cover reset mid-transfer: i_reset after 2 bytes of len=8 -> all outputs at reset values next clock, no o_done, no further bus writes.
REQ-036 SHALL cover fill mode (BUS_DMA_FILL_EN): i_fill=1, i_fill_data=0xA5, dst=0x0400, len=3 -> 0x0400..0x0402 = A5, o_bus_rw never 1 while busy, 6 clocks.
